dec_stage_pipe: RTL and testbench

//  Registered RV32I decode stage with valid/ready handshake between IF and EX.

---
 rtl/dec_stage_pipe.sv | 240 ++++++++++++++++++++++++
 tb/tb_dec_stage_pipe.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_stage_pipe.sv
// RV32I decode stage: combinational decode + operand forwarding feeding a
// registered ID/EX pipeline register with valid/ready handshake and load-use stall.
module dec_stage_pipe #(
    parameter int XLEN          = 32,
    parameter int PC_WIDTH      = 32,
    parameter int REG_IDX_WIDTH = 5,
    parameter bit FWD_EN        = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     if_valid_i,
    output logic                     if_ready_o,
    input  logic [PC_WIDTH-1:0]      pc_i,
    input  logic [31:0]              instr_i,
    output logic [REG_IDX_WIDTH-1:0] rs1_idx_o,
    output logic [REG_IDX_WIDTH-1:0] rs2_idx_o,
    input  logic [XLEN-1:0]          rs1_rdata_i,
    input  logic [XLEN-1:0]          rs2_rdata_i,
    input  logic                     ex_rd_en_i,
    input  logic [REG_IDX_WIDTH-1:0] ex_rd_idx_i,
    input  logic                     ex_is_load_i,
    input  logic [XLEN-1:0]          ex_wdata_i,
    input  logic                     wb_rd_en_i,
    input  logic [REG_IDX_WIDTH-1:0] wb_rd_idx_i,
    input  logic [XLEN-1:0]          wb_wdata_i,
    input  logic                     ex_ready_i,
    output logic                     id_valid_o,
    output logic [PC_WIDTH-1:0]      id_pc_o,
    output logic [31:0]              id_instr_o,
    output logic [REG_IDX_WIDTH-1:0] id_rd_idx_o,
    output logic                     id_rd_en_o,
    output logic [XLEN-1:0]          id_op1_o,
    output logic [XLEN-1:0]          id_op2_o,
    output logic [XLEN-1:0]          id_imm_o,
    output logic [3:0]               id_alu_fun_o,
    output logic                     id_illegal_o
);

    localparam logic [3:0] ALU_FUN_ADD   = 4'd0;
    localparam logic [3:0] ALU_FUN_SUB   = 4'd1;
    localparam logic [3:0] ALU_FUN_SUB_U = 4'd2;
    localparam logic [3:0] ALU_FUN_SLL   = 4'd3;
    localparam logic [3:0] ALU_FUN_XOR   = 4'd4;
    localparam logic [3:0] ALU_FUN_SRL   = 4'd5;
    localparam logic [3:0] ALU_FUN_SRA   = 4'd6;
    localparam logic [3:0] ALU_FUN_OR    = 4'd7;
    localparam logic [3:0] ALU_FUN_AND   = 4'd8;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_ALI   = 7'b0010011;
    localparam logic [6:0] OP_AL    = 7'b0110011;
    localparam logic [6:0] OP_FENCE = 7'b0001111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;

    typedef enum logic [1:0] {OP1_ZERO, OP1_RS1, OP1_PC, OP1_ZIMM} op1_sel_t;
    typedef enum logic [1:0] {OP2_ZERO, OP2_RS2, OP2_IMM} op2_sel_t;

    // Shared register-register / register-immediate function map; alt picks SUB/SRA.
    function automatic logic [3:0] arith_fun(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  arith_fun = alt ? ALU_FUN_SUB : ALU_FUN_ADD;
            3'b001:  arith_fun = ALU_FUN_SLL;
            3'b010:  arith_fun = ALU_FUN_SUB;
            3'b011:  arith_fun = ALU_FUN_SUB_U;
            3'b100:  arith_fun = ALU_FUN_XOR;
            3'b101:  arith_fun = alt ? ALU_FUN_SRA : ALU_FUN_SRL;
            3'b110:  arith_fun = ALU_FUN_OR;
            default: arith_fun = ALU_FUN_AND;
        endcase
    endfunction

    logic [6:0]      opcode;
    logic [2:0]      fun3;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = instr_i[6:0];
    assign fun3   = instr_i[14:12];
    assign imm_i  = XLEN'($signed(instr_i[31:20]));
    assign imm_s  = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
    assign imm_b  = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0}));
    assign imm_u  = XLEN'($signed({instr_i[31:12], 12'b0}));
    assign imm_j  = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0}));

    assign rs1_idx_o = REG_IDX_WIDTH'(instr_i[19:15]);
    assign rs2_idx_o = REG_IDX_WIDTH'(instr_i[24:20]);

    logic            rs1_en, rs2_en, rd_en, illegal;
    logic [XLEN-1:0] imm;
    logic [3:0]      alu_fun;
    op1_sel_t        op1_sel;
    op2_sel_t        op2_sel;

    always_comb begin
        rs1_en  = 1'b0;
        rs2_en  = 1'b0;
        rd_en   = 1'b0;
        illegal = 1'b0;
        imm     = '0;
        alu_fun = ALU_FUN_ADD;
        op1_sel = OP1_ZERO;
        op2_sel = OP2_ZERO;
        case (opcode)
            OP_ALI: begin
                rs1_en = 1'b1; rd_en = 1'b1; imm = imm_i;
                op1_sel = OP1_RS1; op2_sel = OP2_IMM;
                alu_fun = arith_fun(fun3, (fun3 == 3'b101) & instr_i[30]);
            end
            OP_AL: begin
                rs1_en = 1'b1; rs2_en = 1'b1; rd_en = 1'b1;
                op1_sel = OP1_RS1; op2_sel = OP2_RS2;
                alu_fun = arith_fun(fun3, instr_i[30]);
            end
            OP_LD, OP_JALR: begin
                rs1_en = 1'b1; rd_en = 1'b1; imm = imm_i;
                op1_sel = OP1_RS1; op2_sel = OP2_IMM;
            end
            OP_ST: begin
                rs1_en = 1'b1; rs2_en = 1'b1; imm = imm_s;
                op1_sel = OP1_RS1; op2_sel = OP2_IMM;
            end
            OP_BR: begin
                rs1_en = 1'b1; rs2_en = 1'b1; imm = imm_b;
                op1_sel = OP1_RS1; op2_sel = OP2_RS2;
                if (fun3[2:1] == 2'b00)  alu_fun = ALU_FUN_XOR;
                else if (fun3[1])        alu_fun = ALU_FUN_SUB_U;
                else                     alu_fun = ALU_FUN_SUB;
            end
            OP_JAL: begin
                rd_en = 1'b1; imm = imm_j;
                op1_sel = OP1_PC; op2_sel = OP2_IMM;
            end
            OP_AUIPC: begin
                rd_en = 1'b1; imm = imm_u;
                op1_sel = OP1_PC; op2_sel = OP2_IMM;
            end
            OP_LUI: begin
                rd_en = 1'b1; imm = imm_u;
                op1_sel = OP1_ZERO; op2_sel = OP2_IMM;
            end
            OP_SYS: begin
                // CSR immediate forms carry a 5-bit zimm in the rs1 field instead of a register
                rd_en = 1'b1; rs1_en = !fun3[2]; imm = imm_i;
                op1_sel = fun3[2] ? OP1_ZIMM : OP1_RS1;
            end
            OP_FENCE: ;
            default: illegal = 1'b1;
        endcase
    end

    logic [REG_IDX_WIDTH-1:0] src_idx   [2];
    logic [XLEN-1:0]          src_rdata [2];
    logic [XLEN-1:0]          src_val   [2];
    logic [1:0]               src_en;
    logic [1:0]               raw_hit;

    assign src_idx[0]   = rs1_idx_o;
    assign src_idx[1]   = rs2_idx_o;
    assign src_rdata[0] = rs1_rdata_i;
    assign src_rdata[1] = rs2_rdata_i;
    assign src_en       = {rs2_en, rs1_en};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            logic live, ex_match, wb_match;
            assign live     = src_en[gi] & (src_idx[gi] != '0);
            assign ex_match = live & ex_rd_en_i & (src_idx[gi] == ex_rd_idx_i);
            assign wb_match = live & wb_rd_en_i & (src_idx[gi] == wb_rd_idx_i);
            if (FWD_EN) begin : g_fwd
                assign src_val[gi] = (ex_match & !ex_is_load_i) ? ex_wdata_i :
                                     wb_match                   ? wb_wdata_i : src_rdata[gi];
                assign raw_hit[gi] = ex_match & ex_is_load_i;
            end else begin : g_nofwd
                assign src_val[gi] = src_rdata[gi];
                assign raw_hit[gi] = ex_match | wb_match;
            end
        end
    endgenerate

    logic [XLEN-1:0] op1, op2;

    always_comb begin
        case (op1_sel)
            OP1_RS1:  op1 = src_val[0];
            OP1_PC:   op1 = XLEN'(pc_i);
            OP1_ZIMM: op1 = XLEN'(instr_i[19:15]);
            default:  op1 = '0;
        endcase
        case (op2_sel)
            OP2_RS2: op2 = src_val[1];
            OP2_IMM: op2 = imm;
            default: op2 = '0;
        endcase
    end

    logic stall, adv, load;

    assign stall      = if_valid_i & (|raw_hit);
    assign adv        = !id_valid_o | ex_ready_i;
    assign if_ready_o = adv & !stall & !flush_i;
    assign load       = if_ready_o & if_valid_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid_o   <= 1'b0;
            id_pc_o      <= '0;
            id_instr_o   <= '0;
            id_rd_idx_o  <= '0;
            id_rd_en_o   <= 1'b0;
            id_op1_o     <= '0;
            id_op2_o     <= '0;
            id_imm_o     <= '0;
            id_alu_fun_o <= ALU_FUN_ADD;
            id_illegal_o <= 1'b0;
        end else if (flush_i) begin
            id_valid_o <= 1'b0;
        end else if (adv) begin
            id_valid_o <= if_valid_i & !stall;
            if (load) begin
                id_pc_o      <= pc_i;
                id_instr_o   <= instr_i;
                id_rd_idx_o  <= rd_en ? REG_IDX_WIDTH'(instr_i[11:7]) : '0;
                id_rd_en_o   <= rd_en;
                id_op1_o     <= op1;
                id_op2_o     <= op2;
                id_imm_o     <= imm;
                id_alu_fun_o <= alu_fun;
                id_illegal_o <= illegal;
            end
        end
    end

endmodule

// File: tb/tb_dec_stage_pipe.sv
// Directed table-driven bench for dec_stage_pipe plus hand sequences for
// load-use stall, EX back-pressure, flush and asynchronous reset mid-stall.
module tb_dec_stage_pipe;

    localparam logic [3:0] F_ADD = 4'd0, F_SUB = 4'd1, F_SUBU = 4'd2, F_SLL = 4'd3,
                           F_XOR = 4'd4, F_SRL = 4'd5, F_SRA = 4'd6, F_OR = 4'd7, F_AND = 4'd8;
    localparam logic [31:0] A = 32'h1111_0000;
    localparam logic [31:0] B = 32'h0000_2222;

    logic        clk, rst_n, flush_i, if_valid_i, if_ready_o;
    logic [31:0] pc_i, instr_i;
    logic [4:0]  rs1_idx_o, rs2_idx_o;
    logic [31:0] rs1_rdata_i, rs2_rdata_i;
    logic        ex_rd_en_i, ex_is_load_i, wb_rd_en_i, ex_ready_i;
    logic [4:0]  ex_rd_idx_i, wb_rd_idx_i;
    logic [31:0] ex_wdata_i, wb_wdata_i;
    logic        id_valid_o, id_rd_en_o, id_illegal_o;
    logic [31:0] id_pc_o, id_instr_o, id_op1_o, id_op2_o, id_imm_o;
    logic [4:0]  id_rd_idx_o;
    logic [3:0]  id_alu_fun_o;

    dec_stage_pipe dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .if_valid_i(if_valid_i),
        .if_ready_o(if_ready_o), .pc_i(pc_i), .instr_i(instr_i),
        .rs1_idx_o(rs1_idx_o), .rs2_idx_o(rs2_idx_o),
        .rs1_rdata_i(rs1_rdata_i), .rs2_rdata_i(rs2_rdata_i),
        .ex_rd_en_i(ex_rd_en_i), .ex_rd_idx_i(ex_rd_idx_i), .ex_is_load_i(ex_is_load_i),
        .ex_wdata_i(ex_wdata_i), .wb_rd_en_i(wb_rd_en_i), .wb_rd_idx_i(wb_rd_idx_i),
        .wb_wdata_i(wb_wdata_i), .ex_ready_i(ex_ready_i), .id_valid_o(id_valid_o),
        .id_pc_o(id_pc_o), .id_instr_o(id_instr_o), .id_rd_idx_o(id_rd_idx_o),
        .id_rd_en_o(id_rd_en_o), .id_op1_o(id_op1_o), .id_op2_o(id_op2_o),
        .id_imm_o(id_imm_o), .id_alu_fun_o(id_alu_fun_o), .id_illegal_o(id_illegal_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction
    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    typedef struct {
        logic [31:0] instr, pc, rs1d, rs2d;
        logic        exen;
        logic [4:0]  exidx;
        logic        exld;
        logic [31:0] exd;
        logic        wben;
        logic [4:0]  wbidx;
        logic [31:0] wbd;
        logic [31:0] op1, op2, imm;
        logic [3:0]  fun;
        logic        rden;
        logic [4:0]  rd;
        logic        ill;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] instr, pc, rs1d, rs2d,
                                input logic exen, input logic [4:0] exidx, input logic exld, input logic [31:0] exd,
                                input logic wben, input logic [4:0] wbidx, input logic [31:0] wbd,
                                input logic [31:0] op1, op2, imm, input logic [3:0] fun,
                                input logic rden, input logic [4:0] rd, input logic ill);
        vec_t v;
        v.instr = instr; v.pc = pc; v.rs1d = rs1d; v.rs2d = rs2d;
        v.exen = exen; v.exidx = exidx; v.exld = exld; v.exd = exd;
        v.wben = wben; v.wbidx = wbidx; v.wbd = wbd;
        v.op1 = op1; v.op2 = op2; v.imm = imm; v.fun = fun;
        v.rden = rden; v.rd = rd; v.ill = ill;
        return v;
    endfunction

    task automatic clear_hazards();
        ex_rd_en_i = 0; ex_rd_idx_i = 0; ex_is_load_i = 0; ex_wdata_i = 0;
        wb_rd_en_i = 0; wb_rd_idx_i = 0; wb_wdata_i = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t tbl [22];

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = mk(enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13), 32'h100, 32'h0, B, 0,0,0,0, 0,0,0, 32'h0, 32'h5, 32'h5, F_ADD, 1, 5'd1, 0);
        tbl[1]  = mk(enc_i(12'hFFF, 5'd3, 3'd0, 5'd2, 7'h13), 32'h104, A, B, 0,0,0,0, 0,0,0, A, 32'hFFFFFFFF, 32'hFFFFFFFF, F_ADD, 1, 5'd2, 0);
        tbl[2]  = mk(enc_r(7'h20, 5'd7, 5'd6, 3'd0, 5'd5), 32'h108, A, B, 0,0,0,0, 0,0,0, A, B, 32'h0, F_SUB, 1, 5'd5, 0);
        tbl[3]  = mk(enc_i(12'h403, 5'd4, 3'd5, 5'd4, 7'h13), 32'h10C, A, B, 0,0,0,0, 0,0,0, A, 32'h403, 32'h403, F_SRA, 1, 5'd4, 0);
        tbl[4]  = mk(enc_i(12'h003, 5'd4, 3'd5, 5'd4, 7'h13), 32'h110, A, B, 0,0,0,0, 0,0,0, A, 32'h3, 32'h3, F_SRL, 1, 5'd4, 0);
        tbl[5]  = mk(enc_r(7'h00, 5'd3, 5'd2, 3'd3, 5'd1), 32'h114, A, B, 0,0,0,0, 0,0,0, A, B, 32'h0, F_SUBU, 1, 5'd1, 0);
        tbl[6]  = mk(enc_i(12'hFFE, 5'd2, 3'd2, 5'd1, 7'h13), 32'h118, A, B, 0,0,0,0, 0,0,0, A, 32'hFFFFFFFE, 32'hFFFFFFFE, F_SUB, 1, 5'd1, 0);
        tbl[7]  = mk(enc_b(13'h1FF8, 5'd2, 5'd1, 3'd0), 32'h11C, A, B, 0,0,0,0, 0,0,0, A, B, 32'hFFFFFFF8, F_XOR, 0, 5'd0, 0);
        tbl[8]  = mk(enc_b(13'h0010, 5'd2, 5'd1, 3'd6), 32'h120, A, B, 0,0,0,0, 0,0,0, A, B, 32'h10, F_SUBU, 0, 5'd0, 0);
        tbl[9]  = mk(enc_j(21'h000800, 5'd1), 32'h124, A, B, 0,0,0,0, 0,0,0, 32'h124, 32'h800, 32'h800, F_ADD, 1, 5'd1, 0);
        tbl[10] = mk(enc_u(20'h12345, 5'd7, 7'h37), 32'h128, A, B, 0,0,0,0, 0,0,0, 32'h0, 32'h12345000, 32'h12345000, F_ADD, 1, 5'd7, 0);
        tbl[11] = mk(enc_u(20'hFFFFF, 5'd8, 7'h17), 32'h12C, A, B, 0,0,0,0, 0,0,0, 32'h12C, 32'hFFFFF000, 32'hFFFFF000, F_ADD, 1, 5'd8, 0);
        tbl[12] = mk(enc_i(12'd4, 5'd5, 3'd0, 5'd1, 7'h67), 32'h130, A, B, 0,0,0,0, 0,0,0, A, 32'h4, 32'h4, F_ADD, 1, 5'd1, 0);
        tbl[13] = mk(enc_i(12'hFFC, 5'd2, 3'd2, 5'd9, 7'h03), 32'h134, A, B, 0,0,0,0, 0,0,0, A, 32'hFFFFFFFC, 32'hFFFFFFFC, F_ADD, 1, 5'd9, 0);
        tbl[14] = mk(32'hFFFFFFFF, 32'h138, A, B, 0,0,0,0, 0,0,0, 32'h0, 32'h0, 32'h0, F_ADD, 0, 5'd0, 1);
        tbl[15] = mk(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'h13C, A, B, 1,5'd1,0,32'd7, 1,5'd1,32'd9, 32'd7, B, 32'h0, F_ADD, 1, 5'd3, 0);
        tbl[16] = mk(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'h140, A, B, 1,5'd5,0,32'd7, 1,5'd2,32'd9, A, 32'd9, 32'h0, F_ADD, 1, 5'd3, 0);
        tbl[17] = mk(enc_r(7'h00, 5'd2, 5'd0, 3'd0, 5'd3), 32'h144, A, B, 1,5'd0,0,32'd7, 1,5'd0,32'd9, A, B, 32'h0, F_ADD, 1, 5'd3, 0);
        tbl[18] = mk(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'h148, A, B, 0,5'd1,0,32'd7, 1,5'd1,32'd9, 32'd9, B, 32'h0, F_ADD, 1, 5'd3, 0);
        tbl[19] = mk(enc_i(12'h300, 5'd6, 3'd1, 5'd5, 7'h73), 32'h14C, A, B, 1,5'd6,0,32'd7, 0,0,0, 32'd7, 32'h0, 32'h300, F_ADD, 1, 5'd5, 0);
        tbl[20] = mk(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'h150, A, B, 1,5'd5,1,32'd7, 0,0,0, A, B, 32'h0, F_ADD, 1, 5'd3, 0);
        tbl[21] = mk(enc_r(7'h00, 5'd2, 5'd1, 3'd7, 5'd3), 32'h154, A, B, 0,0,0,0, 0,0,0, A, B, 32'h0, F_AND, 1, 5'd3, 0);

        rst_n = 0; flush_i = 0; if_valid_i = 0; ex_ready_i = 1;
        pc_i = 0; instr_i = 0; rs1_rdata_i = 0; rs2_rdata_i = 0;
        clear_hazards();
        #1;
        chk("reset_valid", 32'(id_valid_o), 32'h0);
        chk("reset_illegal", 32'(id_illegal_o), 32'h0);
        chk("reset_rd_en", 32'(id_rd_en_o), 32'h0);
        chk("reset_fun", 32'(id_alu_fun_o), 32'(F_ADD));
        chk("reset_op1", id_op1_o, 32'h0);
        @(negedge clk);
        rst_n = 1;

        // Back-to-back table: each vector accepted and visible one cycle later
        for (int i = 0; i < 22; i++) begin
            instr_i = tbl[i].instr; pc_i = tbl[i].pc;
            rs1_rdata_i = tbl[i].rs1d; rs2_rdata_i = tbl[i].rs2d;
            ex_rd_en_i = tbl[i].exen; ex_rd_idx_i = tbl[i].exidx;
            ex_is_load_i = tbl[i].exld; ex_wdata_i = tbl[i].exd;
            wb_rd_en_i = tbl[i].wben; wb_rd_idx_i = tbl[i].wbidx; wb_wdata_i = tbl[i].wbd;
            if_valid_i = 1; ex_ready_i = 1;
            #1;
            chk($sformatf("v%0d_rs1_idx", i), 32'(rs1_idx_o), 32'(tbl[i].instr[19:15]));
            chk($sformatf("v%0d_rs2_idx", i), 32'(rs2_idx_o), 32'(tbl[i].instr[24:20]));
            chk($sformatf("v%0d_if_ready", i), 32'(if_ready_o), 32'h1);
            tick();
            chk($sformatf("v%0d_valid", i), 32'(id_valid_o), 32'h1);
            chk($sformatf("v%0d_pc", i), id_pc_o, tbl[i].pc);
            chk($sformatf("v%0d_instr", i), id_instr_o, tbl[i].instr);
            chk($sformatf("v%0d_op1", i), id_op1_o, tbl[i].op1);
            chk($sformatf("v%0d_op2", i), id_op2_o, tbl[i].op2);
            chk($sformatf("v%0d_imm", i), id_imm_o, tbl[i].imm);
            chk($sformatf("v%0d_fun", i), 32'(id_alu_fun_o), 32'(tbl[i].fun));
            chk($sformatf("v%0d_rd_en", i), 32'(id_rd_en_o), 32'(tbl[i].rden));
            chk($sformatf("v%0d_rd_idx", i), 32'(id_rd_idx_o), 32'(tbl[i].rd));
            chk($sformatf("v%0d_illegal", i), 32'(id_illegal_o), 32'(tbl[i].ill));
            $display("vec %0d instr=%h op1=%h op2=%h imm=%h fun=%0d", i, instr_i, id_op1_o, id_op2_o, id_imm_o, id_alu_fun_o);
        end

        // Load-use: one bubble, then operands come from WB
        clear_hazards();
        instr_i = enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd2); rs1_rdata_i = A; rs2_rdata_i = B;
        ex_rd_en_i = 1; ex_rd_idx_i = 5'd1; ex_is_load_i = 1; ex_wdata_i = 32'hDEAD;
        #1;
        chk("lu_if_ready_stall", 32'(if_ready_o), 32'h0);
        tick();
        chk("lu_bubble", 32'(id_valid_o), 32'h0);
        $display("load-use stall cycle valid=%0d", id_valid_o);
        clear_hazards();
        wb_rd_en_i = 1; wb_rd_idx_i = 5'd1; wb_wdata_i = 32'h55;
        #1;
        chk("lu_if_ready_go", 32'(if_ready_o), 32'h1);
        tick();
        chk("lu_valid", 32'(id_valid_o), 32'h1);
        chk("lu_op1", id_op1_o, 32'h55);
        chk("lu_op2", id_op2_o, 32'h55);
        $display("load-use accept op1=%h op2=%h", id_op1_o, id_op2_o);

        // EX back-pressure for 3 cycles
        clear_hazards();
        instr_i = enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13); rs1_rdata_i = 0;
        tick();
        chk("bp_valid0", 32'(id_valid_o), 32'h1);
        ex_ready_i = 0;
        instr_i = enc_i(12'd9, 5'd0, 3'd0, 5'd2, 7'h13);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp%0d_if_ready", c), 32'(if_ready_o), 32'h0);
            tick();
            chk($sformatf("bp%0d_valid", c), 32'(id_valid_o), 32'h1);
            chk($sformatf("bp%0d_op2", c), id_op2_o, 32'h5);
            chk($sformatf("bp%0d_rd", c), 32'(id_rd_idx_o), 32'h1);
            $display("backpressure cycle %0d op2=%h", c, id_op2_o);
        end
        ex_ready_i = 1;
        #1;
        chk("bp_release_if_ready", 32'(if_ready_o), 32'h1);
        tick();
        chk("bp_release_op2", id_op2_o, 32'h9);
        chk("bp_release_rd", 32'(id_rd_idx_o), 32'h2);
        $display("backpressure release op2=%h", id_op2_o);

        // Flush while held by EX
        ex_ready_i = 0; flush_i = 1;
        #1;
        chk("fl_if_ready", 32'(if_ready_o), 32'h0);
        tick();
        chk("fl_valid", 32'(id_valid_o), 32'h0);
        flush_i = 0;
        #1;
        chk("fl_after_if_ready", 32'(if_ready_o), 32'h1);
        tick();
        chk("fl_after_valid", 32'(id_valid_o), 32'h1);
        $display("flush done valid=%0d", id_valid_o);

        // Asynchronous reset during a held, stalled state
        ex_ready_i = 1; instr_i = 32'hFFFFFFFF;
        tick();
        chk("rs_pre_illegal", 32'(id_illegal_o), 32'h1);
        ex_ready_i = 0;
        instr_i = enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd2);
        ex_rd_en_i = 1; ex_rd_idx_i = 5'd1; ex_is_load_i = 1;
        #1;
        chk("rs_stall_if_ready", 32'(if_ready_o), 32'h0);
        tick();
        chk("rs_held_valid", 32'(id_valid_o), 32'h1);
        #2;
        rst_n = 0;
        #1;
        chk("rs_valid", 32'(id_valid_o), 32'h0);
        chk("rs_illegal", 32'(id_illegal_o), 32'h0);
        chk("rs_rd_en", 32'(id_rd_en_o), 32'h0);
        chk("rs_pc", id_pc_o, 32'h0);
        chk("rs_instr", id_instr_o, 32'h0);
        chk("rs_imm", id_imm_o, 32'h0);
        chk("rs_fun", 32'(id_alu_fun_o), 32'(F_ADD));
        $display("reset mid-stall valid=%0d illegal=%0d", id_valid_o, id_illegal_o);
        @(negedge clk);
        rst_n = 1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
